// File: rtl/issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// issue_ctrl_if
//   Bundles the instruction-source handshake, the flush control and the issue
//   side outputs of issue_ctrl into one interface.
//
//   Signals:
//     in_valid    source has an instruction word
//     in_instr    {opcode[1:0], RD[4:0], RS1[4:0], RS2[4:0]}
//     in_ready    FIFO can accept a word this cycle
//     flush       drop queued words and clear the scoreboard
//     instr_out   registered instruction driven into the pipeline
//     issue_valid 1 when instr_out carries a real instruction, 0 for a bubble
//     stall_count saturating count of hazard bubbles
//     busy        FIFO non-empty or a write-back still in flight
//
//   Modports:
//     master  instruction source / pipeline side (drives valid, instr, flush)
//     slave   issue_ctrl itself
// -----------------------------------------------------------------------------
interface issue_ctrl_if;
  logic        in_valid;
  logic [16:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic [16:0] instr_out;
  logic        issue_valid;
  logic [15:0] stall_count;
  logic        busy;

  modport master (
    output in_valid, in_instr, flush,
    input  in_ready, instr_out, issue_valid, stall_count, busy
  );

  modport slave (
    input  in_valid, in_instr, flush,
    output in_ready, instr_out, issue_valid, stall_count, busy
  );
endinterface

// File: rtl/issue_ctrl.sv
// -----------------------------------------------------------------------------
// issue_ctrl
//   In-order issue controller in front of the two-stage Tejuino pipeline.
//   Incoming instructions are buffered in a small FIFO. A two-entry
//   scoreboard remembers the destination register of the instruction now on
//   instr_out (S0) and of the one issued the cycle before (S1). If the head
//   instruction reads either of those registers, a NOP bubble is issued
//   instead, because the datapath has no forwarding of its own.
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous, active-high reset (priority over everything)
//     bus   issue_ctrl_if.slave: in_valid/in_instr/in_ready handshake,
//           flush, instr_out, issue_valid, stall_count, busy
//
//   Parameters:
//     DEPTH     FIFO entries, power of two, >= 2
//     NOP_INSTR bubble encoding
//     WB_MASK   bit n set means opcode n writes RD
// -----------------------------------------------------------------------------
module issue_ctrl #(
  parameter int          DEPTH     = 4,
  parameter logic [16:0] NOP_INSTR = 17'h00000,
  parameter logic [3:0]  WB_MASK   = 4'b0110
) (
  input  logic         clk,
  input  logic         rst,
  issue_ctrl_if.slave  bus
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [1:0] op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } instr_t;

  typedef struct packed {
    logic       wb;
    logic [4:0] rd;
  } sb_entry_t;

  // FIFO storage and pointers
  logic [16:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  // Scoreboard: S0 = instruction on instr_out, S1 = the one before it
  sb_entry_t     r_s0;
  sb_entry_t     r_s1;

  // Registered outputs
  logic [16:0]   r_instr_out;
  logic          r_issue_valid;
  logic [15:0]   r_stall_count;

  logic          w_empty;
  logic          w_ready;
  logic          w_push;
  logic          w_haz;
  logic          w_pop;
  instr_t        w_head;

  // A source register is pending if either in-flight entry will write it.
  function automatic logic src_pending(input logic [4:0] rs,
                                       input sb_entry_t s0,
                                       input sb_entry_t s1);
    return (s0.wb && (rs == s0.rd)) || (s1.wb && (rs == s1.rd));
  endfunction

  assign w_empty = (r_count == '0);
  assign w_ready = (r_count < FULL_COUNT);
  assign w_push  = bus.in_valid && w_ready;
  assign w_head  = instr_t'(r_mem[r_rptr]);

  // Both source fields are checked regardless of opcode, and R0 is treated
  // like any other register.
  assign w_haz = !w_empty &&
                 (src_pending(w_head.rs1, r_s0, r_s1) ||
                  src_pending(w_head.rs2, r_s0, r_s1));
  assign w_pop = !w_empty && !w_haz;

  // NOTE: the FIFO array carries no reset; an entry is only ever read after
  // it has been written, and the pointers/count alone define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush && w_push) begin
      r_mem[r_wptr] <= bus.in_instr;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register here sees the pre-edge values of the others (S1 <= S0 relies
  // on it).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_s0          <= '0;
      r_s1          <= '0;
      r_instr_out   <= NOP_INSTR;
      r_issue_valid <= 1'b0;
      r_stall_count <= '0;
    end else if (bus.flush) begin
      // Flush drops queued and incoming words but keeps the stall statistic.
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_s0          <= '0;
      r_s1          <= '0;
      r_instr_out   <= NOP_INSTR;
      r_issue_valid <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      r_s1 <= r_s0;
      if (w_pop) begin
        r_instr_out   <= r_mem[r_rptr];
        r_issue_valid <= 1'b1;
        r_s0          <= '{wb: WB_MASK[w_head.op], rd: w_head.rd};
      end else begin
        r_instr_out   <= NOP_INSTR;
        r_issue_valid <= 1'b0;
        r_s0          <= '0;
      end

      if (w_haz && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
    end
  end

  assign bus.in_ready    = w_ready;
  assign bus.instr_out   = r_instr_out;
  assign bus.issue_valid = r_issue_valid;
  assign bus.stall_count = r_stall_count;
  assign bus.busy        = !w_empty || r_s0.wb || r_s1.wb;

endmodule

// File: doc/issue_ctrl.md
# issue_ctrl

In-order issue controller that sits in front of the two-stage `Tejuino` pipeline and drives its 17-bit `instr` input. It buffers incoming instructions in a small FIFO and tracks the destination registers of the two instructions already in flight. When the head instruction would read a register that has not yet been written back, it inserts NOP bubbles. The datapath has no forwarding and no stall logic of its own, so this block is the only RAW-hazard protection for `Tejuino`.

## Interface

Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `NOP_INSTR`, default 17'h00000: bubble encoding; opcode 2'b00, which Control decodes as R=W=WE=0.
- `WB_MASK`, default 4'b0110: bit n set means opcode n writes RD (01, 10 = ALU ops; 11 = store; 00 = NOP).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: instruction source has a word.
- `in_instr` in 17: {opcode[1:0], RD[4:0], RS1[4:0], RS2[4:0]}.
- `in_ready` out 1: FIFO can accept; equals (count < DEPTH).
- `flush` in 1: synchronous; drops queued instructions and clears the scoreboard.
- `instr_out` out 17: registered; connects to `Tejuino.instr`.
- `issue_valid` out 1: registered; 1 when `instr_out` holds a real instruction, 0 when it holds a bubble.
- `stall_count` out 16: saturating count of hazard bubbles.
- `busy` out 1: FIFO non-empty or any scoreboard entry has wb=1.

## Operation

- **Push:** when `in_valid && in_ready`, `in_instr` is written at the tail. There is no bypass, so the word is visible at the head on the next cycle.
- **Scoreboard:** two entries, S0 (instruction currently on `instr_out`) and S1 (the one issued the cycle before). Each entry is {wb, rd}.
  - Every cycle: S1 <= S0; S0 <= {WB_MASK[op], RD} of the word issued this edge, or {0, x} for a bubble.
- **Hazard:** `haz` = FIFO non-empty AND (head RS1 or head RS2) equals S0.rd with S0.wb=1, or equals S1.rd with S1.wb=1.
  - Both source fields are always checked, whatever the opcode.
  - Register 0 gets no special treatment.
- **Issue decision, each edge:**
  - FIFO non-empty and !haz: `instr_out` <= head, pop, `issue_valid` <= 1.
  - haz: `instr_out` <= NOP_INSTR, `issue_valid` <= 0, no pop, `stall_count` increments (saturates at 16'hFFFF).
  - FIFO empty: `instr_out` <= NOP_INSTR, `issue_valid` <= 0, no count.
- **Push and pop in the same cycle** are both allowed; count is unchanged. When full, `in_ready` is 0 even if a pop occurs that cycle.
- **Pointers:** log2(DEPTH) bits, wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- **`flush`:**
  - Next edge: FIFO empty, S0/S1 wb=0, `instr_out`=NOP_INSTR, `issue_valid`=0.
  - `stall_count` is retained.
  - A push presented in the same cycle is dropped.
- **`rst`:** same as flush, plus `stall_count` <= 0. `rst` has priority over `flush` and over push/pop, including mid-stream.

## Timing

- **Reset values:** `instr_out`=NOP_INSTR, `issue_valid`=0, `stall_count`=0, `in_ready`=1, `busy`=0.
- **Accept-to-issue latency** with an empty FIFO and no hazard: word accepted at edge E appears on `instr_out` after edge E+1.
- **Throughput:** one instruction per cycle for independent streams.
- **Dependency spacing:** a producer on `instr_out` in cycle c (wb=1) is followed by its dependent no earlier than cycle c+3. Back-to-back dependents therefore get exactly 2 bubbles.
- **Producers that release nothing:** stores (opcode 11) and NOPs set wb=0 and never cause stalls.

## Test plan

- **Reset:** assert `rst` for 2 cycles. Check `instr_out`=17'h00000, `issue_valid`=0, `stall_count`=0, `in_ready`=1, `busy`=0.
- **Independent stream:** push 4 ALU ops (opcode 01) with RD=1..4 and sources 10..17, back to back. Check they are issued in 4 consecutive cycles starting 2 edges after the first accept, with `stall_count`=0.
- **RAW hazard:** push {01,RD=5,1,2} then {10,RD=6,5,3}. Check exactly 2 cycles of NOP_INSTR with `issue_valid`=0 between them, and `stall_count`=2.
- **Store does not stall:** push {11,RD=5,1,2} then {01,RD=7,5,5}. Check the two are issued in consecutive cycles with no bubbles.
- **Backpressure and wrap:** with DEPTH=4, chain 6 dependent ops on register 8, holding `in_valid`=1. Check `in_ready` drops to 0 when count=4, all 6 are issued in order, and pointers wrap.
- **Flush and reset mid-stream:** with 3 entries queued and S0.wb=1, pulse `flush`. Check the next issue is NOP_INSTR, `busy`=0, and `stall_count` is held. Then pulse `rst` and check `stall_count`=0.
